// File: rtl/interp_out_buffer.sv
// rtl/interp_out_buffer.sv - round/saturate stage, FWFT FIFO and issue-credit counter after the interpolator
module interp_out_buffer #(
    parameter int DWIDTH = 16,
    parameter int UWIDTH = 8,
    parameter int DEPTH  = 16,
    parameter int PFRAC  = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue,
    output logic                       issue_ok,
    input  logic                       in_valid,
    input  logic [DWIDTH+2*PFRAC-1:0]  in_data,
    input  logic [UWIDTH-1:0]          in_user,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DWIDTH-1:0]          out_data,
    output logic [UWIDTH-1:0]          out_user,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int IW = DWIDTH + 2 * PFRAC;
    localparam int SW = IW + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = DWIDTH + UWIDTH;
    localparam logic [IW:0]   HALF = SW'(1) << (2 * PFRAC - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [IW:0]         sum;
    logic [DWIDTH-1:0]   rounded;
    logic                unused_round_bits;

    logic                rnd_valid;
    logic [DWIDTH-1:0]   rnd_data;
    logic [UWIDTH-1:0]   rnd_user;

    logic [EW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       cred;

    logic                pop;
    logic                full;
    logic                wr_en;

    // Round half up; a carry out of the top means the value no longer fits.
    assign sum               = {1'b0, in_data} + HALF;
    assign rounded           = sum[IW] ? '1 : sum[2*PFRAC +: DWIDTH];
    assign unused_round_bits = ^sum[2*PFRAC-1:0];

    assign pop   = (count_q != '0) && out_ready;
    assign full  = (count_q == FULL);
    assign wr_en = rnd_valid && (!full || pop);

    assign out_valid = (count_q != '0);
    assign out_data  = mem[rd_ptr][EW-1:UWIDTH];
    assign out_user  = mem[rd_ptr][UWIDTH-1:0];
    assign count     = count_q;
    assign issue_ok  = (cred != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
            rnd_user  <= '0;
        end else begin
            rnd_valid <= in_valid;
            rnd_data  <= rounded;
            rnd_user  <= in_user;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= {rnd_data, rnd_user};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Credits cover beats in flight through the interpolator and this block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cred     <= FULL;
            overflow <= 1'b0;
        end else begin
            if (issue && !pop) begin
                if (cred != '0) begin
                    cred <= cred - CW'(1);
                end
            end else if (pop && !issue) begin
                if (cred != FULL) begin
                    cred <= cred + CW'(1);
                end
            end
            if ((issue && cred == '0) || (rnd_valid && full && !pop)) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_interp_out_buffer.sv
// tb/tb_interp_out_buffer.sv - randomized and directed bench for interp_out_buffer against a queue model
module tb_interp_out_buffer;

    localparam int DW = 16;
    localparam int UW = 8;
    localparam int D  = 16;
    localparam int PF = 12;
    localparam int IW = DW + 2 * PF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          issue = 1'b0;
    logic          issue_ok;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic [UW-1:0] in_user = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [UW-1:0] out_user;
    logic [4:0]    count;
    logic          overflow;

    interp_out_buffer #(.DWIDTH(DW), .UWIDTH(UW), .DEPTH(D), .PFRAC(PF)) dut (
        .clk(clk), .rst(rst), .issue(issue), .issue_ok(issue_ok),
        .in_valid(in_valid), .in_data(in_data), .in_user(in_user),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_user(out_user), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] round_sat(input logic [IW-1:0] d);
        longint unsigned v;
        v = (longint'(d) + (64'd1 << (2 * PF - 1))) >> (2 * PF);
        if (v > 64'd65535) return 16'hFFFF;
        return v[DW-1:0];
    endfunction

    // Behavioural model: a queue of stored entries, one in-flight beat, a credit integer.
    logic [DW+UW-1:0] mq[$];
    bit               p_valid = 1'b0;
    logic [DW+UW-1:0] p_ent = '0;
    int               cred = D;
    bit               ovf = 1'b0;
    bit               check_en = 1'b0;

    always @(posedge clk or negedge rst) begin
        bit m_pop;
        bit was_full;
        if (!rst) begin
            mq.delete();
            p_valid = 1'b0;
            cred    = D;
            ovf     = 1'b0;
        end else begin
            m_pop    = (mq.size() != 0) && out_ready;
            was_full = (mq.size() == D);
            if (issue && cred == 0) ovf = 1'b1;
            if (issue && !m_pop) begin
                if (cred > 0) cred--;
            end else if (m_pop && !issue) begin
                if (cred < D) cred++;
            end
            if (m_pop) void'(mq.pop_front());
            if (p_valid) begin
                if (!was_full || m_pop) mq.push_back(p_ent);
                else ovf = 1'b1;
            end
            p_valid = in_valid;
            p_ent   = {round_sat(in_data), in_user};
        end
    end

    always @(negedge clk) begin
        if (rst && check_en) begin
            chk("issue_ok", issue_ok, cred != 0);
            chk("out_valid", out_valid, mq.size() != 0);
            chk("count", count, mq.size());
            chk("overflow", overflow, ovf);
            if (mq.size() != 0) begin
                chk("out_data", out_data, mq[0][DW+UW-1:UW]);
                chk("out_user", out_user, mq[0][UW-1:0]);
            end
        end
    end

    bit stream_mon = 1'b0;
    int s_pops = 0;
    int s_bubbles = 0;
    always @(negedge clk) begin
        if (stream_mon) begin
            if (s_pops > 0 && s_pops < 100 && !out_valid) s_bubbles++;
            if (out_valid && out_ready) s_pops++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit iss, input bit iv, input logic [IW-1:0] d,
                         input logic [UW-1:0] u, input bit rdy);
        issue = iss; in_valid = iv; in_data = d; in_user = u; out_ready = rdy;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_issue_ok"}, issue_ok, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_user"}, out_user, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    logic [IW-1:0] rv_in  [3];
    logic [DW-1:0] rv_out [3];
    logic [63:0]   r;

    initial begin
        rv_in[0] = 40'h00037FFFFF; rv_out[0] = 16'h0003;
        rv_in[1] = 40'h0003800000; rv_out[1] = 16'h0004;
        rv_in[2] = 40'hFFFF800000; rv_out[2] = 16'hFFFF;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        rst = 1'b1;
        check_en = 1'b1;
        tick();
        @(negedge clk);
        check_reset_outputs("idle");

        // Rounding vectors with latency 2
        for (int k = 0; k < 3; k++) begin
            tick();
            drive(1, 1, rv_in[k], UW'(k + 1), 1);
            tick();
            drive(0, 0, '0, '0, 1);
            @(negedge clk);
            chk("lat1_out_valid", out_valid, 0);
            tick();
            @(negedge clk);
            chk("lat2_out_valid", out_valid, 1);
            chk("round_value", out_data, rv_out[k]);
            tick();
        end
        drive(0, 0, '0, '0, 0);
        tick();

        // Credit exhaustion with tags 0..15
        for (int i = 0; i < 16; i++) begin
            r = {$urandom, $urandom};
            drive(1, 1, r[IW-1:0], UW'(i), 0);
            if (i == 15) chk("issue_ok_before_16th", issue_ok, 1);
            tick();
        end
        drive(0, 0, '0, '0, 0);
        @(negedge clk);
        chk("issue_ok_after_16th", issue_ok, 0);
        tick();
        tick();
        chk("count_full", count, 16);
        out_ready = 1'b1;
        @(negedge clk);
        chk("pop_tag_0", out_user, 0);
        chk("pop_count_0", count, 16);
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("issue_ok_after_pop", issue_ok, 1);
        chk("count_after_pop", count, 15);
        tick();
        out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            chk("drain_tag", out_user, i);
            chk("drain_count", count, 16 - i);
        end
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("drained_count", count, 0);

        // Refill, then write and pop together at count 16
        tick();
        for (int i = 0; i < 16; i++) begin
            r = {$urandom, $urandom};
            drive(1, 1, r[IW-1:0], UW'(100 + i), 0);
            tick();
        end
        drive(0, 0, '0, '0, 0);
        tick();
        tick();
        chk("refill_count", count, 16);
        chk("refill_issue_ok", issue_ok, 0);
        chk("refill_overflow", overflow, 0);
        for (int c = 0; c < 6; c++) begin
            r = {$urandom, $urandom};
            drive(0, c < 5, r[IW-1:0], UW'(200 + c), c >= 1);
            tick();
            if (c >= 1) begin
                @(negedge clk);
                chk("full_push_pop_count", count, 16);
                #4;
            end
        end
        drive(0, 0, '0, '0, 0);
        @(negedge clk);
        chk("head_after_wrap", out_user, 105);
        chk("overflow_after_push_pop", overflow, 0);

        // Spend remaining credits, then issue with pop at zero credit
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, '0, '0, 0);
            tick();
        end
        drive(0, 0, '0, '0, 0);
        @(negedge clk);
        chk("cred_zero_issue_ok", issue_ok, 0);
        chk("cred_zero_overflow", overflow, 0);
        tick();
        drive(1, 0, '0, '0, 1);
        tick();
        drive(0, 0, '0, '0, 0);
        @(negedge clk);
        chk("issue_pop_cred_zero", issue_ok, 0);
        chk("issue_at_zero_overflow", overflow, 1);
        chk("issue_pop_count", count, 15);
        tick();

        // Overfill: 17th beat is dropped and the head does not move
        drive(0, 1, 40'h0001000000, 8'hEE, 0);
        tick();
        drive(0, 1, 40'h0002000000, 8'hEF, 0);
        tick();
        drive(0, 0, '0, '0, 0);
        repeat (3) tick();
        chk("overfill_count", count, 16);
        chk("overfill_head", out_user, 106);
        chk("overflow_sticky", overflow, 1);

        // Reset mid-stream with 5 entries stored
        rst = 1'b0;
        #1;
        rst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            r = {$urandom, $urandom};
            drive(1, 1, r[IW-1:0], UW'(i + 50), 0);
            tick();
        end
        drive(0, 0, '0, '0, 0);
        repeat (2) tick();
        chk("five_stored", count, 5);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        tick();
        rst = 1'b1;
        tick();

        // Back-to-back streaming
        stream_mon = 1'b1;
        for (int i = 0; i < 100; i++) begin
            r = {$urandom, $urandom};
            drive(1, 1, r[IW-1:0], UW'($urandom), 1);
            tick();
        end
        drive(0, 0, '0, '0, 1);
        repeat (4) tick();
        stream_mon = 1'b0;
        chk("stream_pops", s_pops, 100);
        chk("stream_bubbles", s_bubbles, 0);

        // Randomized traffic obeying the credit rule, with boundary-heavy fractions
        for (int c = 0; c < 1500; c++) begin
            bit iss;
            logic [23:0] frac;
            r = {$urandom, $urandom};
            case ($urandom_range(3, 0))
                0: frac = 24'h7FFFFF;
                1: frac = 24'h800000;
                default: frac = r[23:0];
            endcase
            iss = issue_ok && ($urandom_range(3, 0) != 0);
            drive(iss, iss, {($urandom_range(7, 0) == 0) ? 16'hFFFF : r[55:40], frac},
                  UW'($urandom), $urandom_range(2, 0) != 0);
            tick();
        end
        drive(0, 0, '0, '0, 1);
        repeat (20) tick();
        chk("final_count", count, 0);
        chk("final_issue_ok", issue_ok, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
